// File: rtl/scr1_coproc_instr_fifo.sv
// rtl/scr1_coproc_instr_fifo.sv - FWFT micro-instruction FIFO between SCR1 pipeline and RLWE coprocessor
// Optional zero-latency empty-FIFO bypass: define SCR1_COPROC_FIFO_BYPASS_EN.
module scr1_coproc_instr_fifo #(
    parameter int INSTR_W      = 64,
    parameter int DEPTH        = 8,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [INSTR_W-1:0]         in_instr,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [INSTR_W-1:0]         out_instr,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic                       overflow_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] AFULL_TH = PTR_W'(DEPTH - AFULL_MARGIN);

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   count_r;
    logic               ovf_r;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic bypass;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);

    assign in_ready = !full;

`ifdef SCR1_COPROC_FIFO_BYPASS_EN
    // An instruction offered to an empty FIFO is shown directly; if taken now it never touches storage.
    assign bypass    = empty && in_valid && !flush;
    assign out_valid = !empty || bypass;
    assign out_instr = empty ? in_instr : mem[rd_ptr[IDX_W-1:0]];
    assign push      = in_valid && in_ready && !flush && !(bypass && out_ready);
    assign pop       = !empty && out_ready && !flush;
`else
    assign bypass    = 1'b0;
    assign out_valid = !empty;
    assign out_instr = mem[rd_ptr[IDX_W-1:0]];
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
`endif

    assign count        = count_r;
    assign almost_full  = (count_r >= AFULL_TH);
    assign overflow_err = ovf_r;

    // Storage is not reset; out_instr is meaningless while out_valid is low.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[IDX_W-1:0]] <= in_instr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
            ovf_r   <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
            ovf_r   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count_r <= count_r + PTR_W'(1);
            end else if (pop && !push) begin
                count_r <= count_r - PTR_W'(1);
            end
            if (in_valid && full) begin
                ovf_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scr1_coproc_instr_fifo.sv
// tb/tb_scr1_coproc_instr_fifo.sv - scoreboard bench for scr1_coproc_instr_fifo (honours SCR1_COPROC_FIFO_BYPASS_EN)
module tb_scr1_coproc_instr_fifo;

    localparam int INSTR_W      = 64;
    localparam int DEPTH        = 4;
    localparam int AFULL_MARGIN = 1;

    logic               clk;
    logic               rst;
    logic               flush;
    logic               in_valid;
    logic [INSTR_W-1:0] in_instr;
    logic               in_ready;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic               out_ready;
    logic [2:0]         count;
    logic               almost_full;
    logic               overflow_err;

    scr1_coproc_instr_fifo #(
        .INSTR_W      (INSTR_W),
        .DEPTH        (DEPTH),
        .AFULL_MARGIN (AFULL_MARGIN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_instr     (in_instr),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_instr    (out_instr),
        .out_ready    (out_ready),
        .count        (count),
        .almost_full  (almost_full),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [INSTR_W-1:0] sbq [$];
    bit                 mov;
    int                 n_vec;
    int                 n_err;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Drive one cycle, check outputs mid-cycle against the scoreboard, then advance the model at the edge.
    task automatic step(input logic iv, input logic [63:0] d, input logic ordy, input logic fl);
        int n;
        bit byp;
        in_valid  = iv;
        in_instr  = d;
        out_ready = ordy;
        flush     = fl;
        #3;
        n   = sbq.size();
        byp = 1'b0;
`ifdef SCR1_COPROC_FIFO_BYPASS_EN
        byp = (n == 0) && iv && !fl;
`endif
        check_eq("out_valid", 64'(out_valid), 64'((n != 0) || byp));
        if (n != 0)
            check_eq("out_instr", out_instr, sbq[0]);
        else if (byp)
            check_eq("bypass_instr", out_instr, d);
        check_eq("in_ready", 64'(in_ready), 64'(n < DEPTH));
        check_eq("count", 64'(count), 64'(n));
        check_eq("almost_full", 64'(almost_full), 64'(n >= DEPTH - AFULL_MARGIN));
        check_eq("overflow_err", 64'(overflow_err), 64'(mov));
        @(posedge clk);
        if (fl) begin
            sbq.delete();
            mov = 1'b0;
        end else begin
            if (iv && n == DEPTH) mov = 1'b1;
            if (n > 0 && ordy) void'(sbq.pop_front());
            if (iv && n < DEPTH && !(byp && ordy)) sbq.push_back(d);
        end
        #1;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        mov       = 1'b0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset
        step(0, 64'h0, 0, 0);
        step(0, 64'h0, 1, 0);

        // Fill then drain in order
        for (int i = 0; i < 4; i++) step(1, 64'hA0 + 64'(i), 0, 0);
        step(0, 64'h0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 64'h0, 1, 0);
        step(0, 64'h0, 0, 0);

        // Preload two, then simultaneous push/pop across pointer wrap
        step(1, 64'h10, 0, 0);
        step(1, 64'h11, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 64'h20 + 64'(i), 1, 0);
        for (int i = 0; i < 3; i++) step(0, 64'h0, 1, 0);

        // Overflow while full, offered word is dropped, flush clears the sticky flag
        for (int i = 0; i < 4; i++) step(1, 64'h30 + 64'(i), 0, 0);
        step(1, 64'hBB, 0, 0);
        step(0, 64'h0, 0, 0);
        step(0, 64'h0, 1, 0);
        step(0, 64'h0, 0, 1);
        step(0, 64'h0, 0, 0);

        // Flush wins over simultaneous push and pop
        step(1, 64'h40, 0, 0);
        step(1, 64'h41, 0, 0);
        step(1, 64'h42, 1, 1);
        step(0, 64'h0, 1, 0);

        // Asynchronous reset between clock edges
        for (int i = 0; i < 3; i++) step(1, 64'h50 + 64'(i), 0, 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check_eq("async_rst_out_valid", 64'(out_valid), 64'(0));
        check_eq("async_rst_count", 64'(count), 64'(0));
        check_eq("async_rst_in_ready", 64'(in_ready), 64'(1));
        sbq.delete();
        mov = 1'b0;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(0, 64'h0, 0, 0);

        // Empty-FIFO offer with the consumer ready, then a normal push behind it
        step(1, 64'hCC, 1, 0);
        step(0, 64'h0, 0, 0);
        step(1, 64'hCD, 0, 0);
        step(0, 64'h0, 1, 0);
        step(0, 64'h0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
